// File: rtl/enc_pkg.sv
// Shared types and helpers for the quadrature encoder controller.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
//
// Contents:
//   quad_state_t - phase FSM states, named by the filtered {a,b} pair
//   quad_dir_t   - classification of a phase transition
//   ab_to_state  - maps a filtered {a,b} pair onto its phase state
//   cw_next      - successor of a phase state in clockwise order
//   quad_dir     - direction of a transition between two phase states
//   cnt_width    - bit width for a counter that counts 0..n-1 (minimum 1)
package enc_pkg;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    S00  = 3'd1,
    S10  = 3'd2,
    S11  = 3'd3,
    S01  = 3'd4
  } quad_state_t;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,  // no movement, or leaving INIT
    DIR_CW      = 2'd1,  // +1 quarter-step
    DIR_CCW     = 2'd2,  // -1 quarter-step
    DIR_ILLEGAL = 2'd3   // both bits changed at once
  } quad_dir_t;

  // ab[1] is channel A, ab[0] is channel B.
  function automatic quad_state_t ab_to_state(input logic [1:0] ab);
    case (ab)
      2'b00:   return S00;
      2'b10:   return S10;
      2'b11:   return S11;
      default: return S01;
    endcase
  endfunction

  // Clockwise order is S00 -> S10 -> S11 -> S01 -> S00.
  function automatic quad_state_t cw_next(input quad_state_t s);
    case (s)
      S00:     return S10;
      S10:     return S11;
      S11:     return S01;
      S01:     return S00;
      default: return INIT;
    endcase
  endfunction

  // Leaving INIT only establishes the phase reference, so it carries no
  // direction. Any pair that is neither a CW nor a CCW neighbour is a
  // diagonal jump.
  function automatic quad_dir_t quad_dir(input quad_state_t from_s,
                                         input quad_state_t to_s);
    if (from_s == INIT || to_s == INIT || from_s == to_s) begin
      return DIR_NONE;
    end else if (cw_next(from_s) == to_s) begin
      return DIR_CW;
    end else if (cw_next(to_s) == from_s) begin
      return DIR_CCW;
    end else begin
      return DIR_ILLEGAL;
    end
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchronizer plus stability filter for the encoder pin pair.
// Latency: filtered value changes DEB_CYCLES+2 clocks after the first sampling edge.
// Backpressure: none; free-running filter, chg_o is a one-cycle strobe.
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   ab_i    - raw {a,b} pins (asynchronous)
//   ab_o    - filtered {a,b}, reset value 2'b00
//   chg_o   - one-cycle strobe, high in the cycle ab_o takes a new accepted value
module enc_debounce
  import enc_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] ab_i,
  output logic [1:0] ab_o,
  output logic       chg_o
);

  localparam int                 CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       samp_q;   // sample currently being qualified
  logic [1:0]       filt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             init_q;   // set once the first stable sample is accepted
  logic             chg_q;
  logic             accept;

  // cnt_q counts how many further cycles samp_q has held its value, so
  // cnt_q == DEB_CYCLES-1 means DEB_CYCLES consecutive identical samples.
  // It saturates there so a long-stable value does not wrap back around.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != samp_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Before the first acceptance the filtered value only holds its reset
  // value, so the first stable sample is accepted even if it equals it;
  // that lets the phase FSM leave INIT whatever the pins are at power-up.
  assign accept = (cnt_q == CNT_LAST) && ((samp_q != filt_q) || !init_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      samp_q  <= 2'b00;
      filt_q  <= 2'b00;
      cnt_q   <= '0;
      init_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= ab_i;
      sync2_q <= sync1_q;
      samp_q  <= sync2_q;
      cnt_q   <= cnt_d;
      chg_q   <= accept;
      if (accept) begin
        filt_q <= samp_q;
        init_q <= 1'b1;
      end
    end
  end

  assign ab_o  = filt_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/enc_count_ctrl.sv
// Quadrature encoder to bounded position counter (phase FSM, detent accumulator, counter).
// Latency: step pulse and count update DEB_CYCLES+3 clocks after the first sampling edge.
// Backpressure: none; pulses are one cycle and cannot be stalled.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   a, b     - raw encoder channels (asynchronous)
//   enable   - when low, steps are still pulsed but count holds
//   clr      - synchronous clear of count and detent accumulator
//   count    - current position, MIN_VAL..MAX_VAL
//   step_cw  - one-cycle pulse per completed CW detent
//   step_ccw - one-cycle pulse per completed CCW detent
//   at_limit - high while count is at MIN_VAL or MAX_VAL
//   err      - one-cycle pulse on a diagonal phase jump
module enc_count_ctrl
  import enc_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = 255,
  parameter int WRAP       = 1,
  parameter int DEB_CYCLES = 4,
  parameter int DETENT     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             enable,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             at_limit,
  output logic             err
);

  // Signed accumulator wide enough to hold +/-DETENT.
  localparam int                      ACC_W   = $clog2(DETENT + 1) + 1;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_POS = ACC_W'(DETENT);
  localparam logic signed [ACC_W-1:0] ACC_NEG = -ACC_POS;
  localparam logic [WIDTH-1:0]        MIN_C   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0]        MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0]        ONE_C   = WIDTH'(1);

  logic [1:0]              filt_ab;
  logic                    filt_chg;

  quad_state_t             state_q, state_d;
  quad_state_t             new_state;
  quad_dir_t               dir;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]        count_q, count_d;
  logic                    step_cw_q, step_cw_d;
  logic                    step_ccw_q, step_ccw_d;
  logic                    err_q, err_d;

  enc_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .ab_i   ({a, b}),
    .ab_o   (filt_ab),
    .chg_o  (filt_chg)
  );

  always_comb begin
    state_d    = state_q;
    new_state  = ab_to_state(filt_ab);
    dir        = DIR_NONE;
    acc_step   = acc_q;
    acc_d      = acc_q;
    step_cw_d  = 1'b0;
    step_ccw_d = 1'b0;
    err_d      = 1'b0;
    count_d    = count_q;

    // The FSM only moves on an accepted filtered change, so at most one
    // quarter-step is taken per change.
    if (filt_chg) begin
      dir     = quad_dir(state_q, new_state);
      state_d = new_state;
      case (dir)
        DIR_CW:      acc_step = acc_q + ACC_ONE;
        DIR_CCW:     acc_step = acc_q - ACC_ONE;
        DIR_ILLEGAL: err_d    = 1'b1;
        default:     acc_step = acc_q;
      endcase
    end

    // A full detent emits its pulse and restarts the accumulator; a
    // reversal mid-detent just walks the accumulator back toward zero.
    if (acc_step == ACC_POS) begin
      step_cw_d = 1'b1;
      acc_d     = '0;
    end else if (acc_step == ACC_NEG) begin
      step_ccw_d = 1'b1;
      acc_d      = '0;
    end else begin
      acc_d = acc_step;
    end

    // clr wins over a same-cycle step; the step pulse itself still fires.
    if (clr) begin
      count_d = MIN_C;
      acc_d   = '0;
    end else if (enable && step_cw_d) begin
      if (count_q == MAX_C) begin
        count_d = (WRAP != 0) ? MIN_C : MAX_C;
      end else begin
        count_d = count_q + ONE_C;
      end
    end else if (enable && step_ccw_d) begin
      if (count_q == MIN_C) begin
        count_d = (WRAP != 0) ? MAX_C : MIN_C;
      end else begin
        count_d = count_q - ONE_C;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      acc_q      <= '0;
      count_q    <= MIN_C;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
      err_q      <= err_d;
    end
  end

  assign count    = count_q;
  assign step_cw  = step_cw_q;
  assign step_ccw = step_ccw_q;
  assign err      = err_q;
  assign at_limit = (count_q == MIN_C) || (count_q == MAX_C);

endmodule

// File: tb/tb_enc_count_ctrl.sv
module tb_enc_count_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a, b, enable, clr;
  logic [7:0] count, count_s;
  logic       step_cw, step_ccw, at_limit, err;
  logic       step_cw_s, step_ccw_s, at_limit_s, err_s;

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor: counts pulses and flags overlaps / pulses wider than 1 cycle.
  int   cw_n = 0, ccw_n = 0, err_n = 0, cw_s_n = 0;
  int   overlap_n = 0, wide_n = 0;
  logic p_cw = 1'b0, p_ccw = 1'b0, p_err = 1'b0;

  always #5 clk = ~clk;

  enc_count_ctrl #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .WRAP(1), .DEB_CYCLES(4), .DETENT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .enable(enable), .clr(clr),
    .count(count), .step_cw(step_cw), .step_ccw(step_ccw),
    .at_limit(at_limit), .err(err)
  );

  enc_count_ctrl #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .WRAP(0), .DEB_CYCLES(4), .DETENT(4)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .enable(enable), .clr(clr),
    .count(count_s), .step_cw(step_cw_s), .step_ccw(step_ccw_s),
    .at_limit(at_limit_s), .err(err_s)
  );

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (step_cw === 1'b1)   cw_n++;
      if (step_ccw === 1'b1)  ccw_n++;
      if (err === 1'b1)       err_n++;
      if (step_cw_s === 1'b1) cw_s_n++;
      if (step_cw === 1'b1 && step_ccw === 1'b1) overlap_n++;
      if ((step_cw === 1'b1 && p_cw) || (step_ccw === 1'b1 && p_ccw) ||
          (err === 1'b1 && p_err)) wide_n++;
    end
    p_cw  = (step_cw === 1'b1);
    p_ccw = (step_ccw === 1'b1);
    p_err = (err === 1'b1);
  end

  // Set {a,b} just after a rising edge and keep it for 'hold' sampling edges.
  task automatic drive(input logic [1:0] ab, input int hold);
    @(posedge clk); #1;
    a = ab[1];
    b = ab[0];
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic detent_cw();
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
  endtask

  task automatic detent_ccw();
    drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
  endtask

  task automatic apply_reset(input logic [1:0] ab);
    reset_n = 1'b0;
    a = ab[1];
    b = ab[0];
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    clr    = 1'b0;
    reset_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (at_limit !== 1'b1) begin n_bad++; $display("FAIL rst_at_limit: got %b want 1", at_limit); end
    n_cmp++; if ({step_cw, step_ccw, err} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses: got %b want 000", {step_cw, step_ccw, err}); end
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL rst_hold_count: got %0d want 0", count); end
    n_cmp++; if (at_limit !== 1'b1) begin n_bad++; $display("FAIL rst_hold_at_limit: got %b want 1", at_limit); end
    n_cmp++; if (err_n != 0) begin n_bad++; $display("FAIL rst_hold_err: got %0d pulses want 0", err_n); end
    n_cmp++; if (cw_n + ccw_n != 0) begin n_bad++; $display("FAIL rst_hold_steps: got %0d pulses want 0", cw_n + ccw_n); end
  endtask

  task automatic test_cw_latency();
    int cw0;
    int k;
    apply_reset(2'b00);
    repeat (20) @(posedge clk);
    cw0 = cw_n;
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10);
    n_cmp++; if (cw_n != cw0) begin n_bad++; $display("FAIL cw_early_step: got %0d pulses want 0", cw_n - cw0); end
    @(posedge clk); #1;
    a = 1'b0;
    b = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (step_cw === 1'b1) begin
        k = i;
        break;
      end
    end
    // i = 1 is the first sampling edge; the pulse is 7 edges after it.
    n_cmp++; if (k - 1 != 7) begin n_bad++; $display("FAIL cw_latency: got %0d edges want 7", k - 1); end
    n_cmp++; if (count !== 8'd1) begin n_bad++; $display("FAIL cw_count: got %0d want 1", count); end
    @(posedge clk); #1;
    n_cmp++; if (step_cw !== 1'b0) begin n_bad++; $display("FAIL cw_pulse_width: got %b want 0", step_cw); end
    n_cmp++; if (at_limit !== 1'b0) begin n_bad++; $display("FAIL cw_at_limit: got %b want 0", at_limit); end
    repeat (5) @(posedge clk);
    n_cmp++; if (cw_n - cw0 != 1) begin n_bad++; $display("FAIL cw_pulse_count: got %0d want 1", cw_n - cw0); end
  endtask

  task automatic test_wrap();
    int cw0, cws0;
    for (int i = 0; i < 8; i++) detent_cw();
    #1;
    n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL wrap_pre_count: got %0d want 9", count); end
    n_cmp++; if (count_s !== 8'd9) begin n_bad++; $display("FAIL sat_pre_count: got %0d want 9", count_s); end
    n_cmp++; if (at_limit !== 1'b1) begin n_bad++; $display("FAIL wrap_at_max: got %b want 1", at_limit); end
    cw0  = cw_n;
    cws0 = cw_s_n;
    detent_cw();
    #1;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL wrap_count: got %0d want 0", count); end
    n_cmp++; if (count_s !== 8'd9) begin n_bad++; $display("FAIL sat_count: got %0d want 9", count_s); end
    n_cmp++; if (cw_n - cw0 != 1) begin n_bad++; $display("FAIL wrap_step: got %0d want 1", cw_n - cw0); end
    n_cmp++; if (cw_s_n - cws0 != 1) begin n_bad++; $display("FAIL sat_step: got %0d want 1", cw_s_n - cws0); end
  endtask

  task automatic test_partial_reversal();
    int cw0, ccw0;
    cw0  = cw_n;
    ccw0 = ccw_n;
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
    #1;
    n_cmp++; if ((cw_n - cw0) + (ccw_n - ccw0) != 0) begin n_bad++; $display("FAIL unwind_steps: got %0d want 0", (cw_n - cw0) + (ccw_n - ccw0)); end
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL unwind_count: got %0d want 0", count); end
    detent_ccw();
    #1;
    n_cmp++; if (ccw_n - ccw0 != 1) begin n_bad++; $display("FAIL ccw_step: got %0d want 1", ccw_n - ccw0); end
    n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL ccw_wrap_count: got %0d want 9", count); end
    n_cmp++; if (count_s !== 8'd8) begin n_bad++; $display("FAIL sat_ccw_count: got %0d want 8", count_s); end
  endtask

  task automatic test_glitch_and_jump();
    int cw0, ccw0, err0;
    cw0  = cw_n;
    ccw0 = ccw_n;
    err0 = err_n;
    drive(2'b10, 3);
    drive(2'b00, 12);
    n_cmp++; if (err_n != err0) begin n_bad++; $display("FAIL glitch_err: got %0d want 0", err_n - err0); end
    n_cmp++; if ((cw_n - cw0) + (ccw_n - ccw0) != 0) begin n_bad++; $display("FAIL glitch_steps: got %0d want 0", (cw_n - cw0) + (ccw_n - ccw0)); end
    drive(2'b11, 10);
    #1;
    n_cmp++; if (err_n - err0 != 1) begin n_bad++; $display("FAIL jump_err: got %0d want 1", err_n - err0); end
    n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL jump_count: got %0d want 9", count); end
    drive(2'b00, 10);
    #1;
    n_cmp++; if (err_n - err0 != 2) begin n_bad++; $display("FAIL jump_back_err: got %0d want 2", err_n - err0); end
    n_cmp++; if ((cw_n - cw0) + (ccw_n - ccw0) != 0) begin n_bad++; $display("FAIL jump_steps: got %0d want 0", (cw_n - cw0) + (ccw_n - ccw0)); end
    n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL jump_back_count: got %0d want 9", count); end
  endtask

  task automatic test_clr();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL clr_count: got %0d want 0", count); end
    for (int i = 0; i < 5; i++) detent_cw();
    #1;
    n_cmp++; if (count !== 8'd5) begin n_bad++; $display("FAIL clr_pre_count: got %0d want 5", count); end
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10);
    @(posedge clk); #1;
    a = 1'b0;
    b = 1'b0;
    repeat (7) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_cmp++; if (step_cw !== 1'b1) begin n_bad++; $display("FAIL clr_same_cycle_step: got %b want 1", step_cw); end
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL clr_same_cycle_count: got %0d want 0", count); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL clr_after_count: got %0d want 0", count); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_enable();
    int cw0, ccw0;
    cw0 = cw_n;
    @(posedge clk); #1 enable = 1'b0;
    for (int i = 0; i < 3; i++) detent_cw();
    #1;
    n_cmp++; if (cw_n - cw0 != 3) begin n_bad++; $display("FAIL enable_steps: got %0d want 3", cw_n - cw0); end
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL enable_hold_count: got %0d want 0", count); end
    enable = 1'b1;
    ccw0 = ccw_n;
    detent_ccw();
    #1;
    n_cmp++; if (ccw_n - ccw0 != 1) begin n_bad++; $display("FAIL reenable_step: got %0d want 1", ccw_n - ccw0); end
    n_cmp++; if (count !== 8'd9) begin n_bad++; $display("FAIL reenable_count: got %0d want 9", count); end
  endtask

  task automatic test_reset_mid_detent();
    int cw0, err0;
    drive(2'b10, 10); drive(2'b11, 10);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++; if (count !== 8'd0) begin n_bad++; $display("FAIL async_rst_count: got %0d want 0", count); end
    n_cmp++; if (at_limit !== 1'b1) begin n_bad++; $display("FAIL async_rst_at_limit: got %b want 1", at_limit); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    err0 = err_n;
    cw0  = cw_n;
    repeat (20) @(posedge clk);
    n_cmp++; if (err_n != err0) begin n_bad++; $display("FAIL reinit_err: got %0d want 0", err_n - err0); end
    drive(2'b01, 10); drive(2'b00, 10);
    n_cmp++; if (cw_n != cw0) begin n_bad++; $display("FAIL acc_cleared: got %0d pulses want 0", cw_n - cw0); end
    drive(2'b10, 10); drive(2'b11, 10);
    #1;
    n_cmp++; if (cw_n - cw0 != 1) begin n_bad++; $display("FAIL post_rst_step: got %0d want 1", cw_n - cw0); end
    n_cmp++; if (count !== 8'd1) begin n_bad++; $display("FAIL post_rst_count: got %0d want 1", count); end
  endtask

  initial begin
    a = 1'b0;
    b = 1'b0;
    enable = 1'b1;
    clr = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_cw_latency();
    test_wrap();
    test_partial_reversal();
    test_glitch_and_jump();
    test_clr();
    test_enable();
    test_reset_mid_detent();
    n_cmp++; if (overlap_n != 0) begin n_bad++; $display("FAIL step_overlap: got %0d want 0", overlap_n); end
    n_cmp++; if (wide_n != 0) begin n_bad++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_n); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enc_count_ctrl.md
# enc_count_ctrl

Quadrature-encoder controller that turns raw rotary-encoder pins into a bounded position count for the display/UI datapath. It synchronizes and debounces both channels, tracks the Gray-code phase with a state machine, groups quarter-steps into detent steps, and updates a wrap-or-saturate counter. It sits between the board encoder pins and any consumer of a user-set value, such as a frequency select or a 7-segment digit.

## Interface
- WIDTH, 8: count width in bits.
- MIN_VAL, 0: lowest count value; also the reset and clear value.
- MAX_VAL, 255: highest count value; must satisfy MIN_VAL < MAX_VAL ≤ 2^WIDTH−1.
- WRAP, 1: 1 = wrap around at the limits; 0 = saturate at the limits.
- DEB_CYCLES, 4: consecutive identical synchronized samples required to accept a new a/b value (≥1).
- DETENT, 4: quarter-steps per detent (1, 2 or 4).
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- a  in  1  raw encoder channel A (asynchronous).
- b  in  1  raw encoder channel B (asynchronous).
- enable  in  1  when 0, steps are still detected and pulsed but count holds.
- clr  in  1  synchronous clear of count and detent accumulator.
- count  out  WIDTH  current position.
- step_cw  out  1  one-cycle pulse per completed CW detent.
- step_ccw  out  1  one-cycle pulse per completed CCW detent.
- at_limit  out  1  high while count == MIN_VAL or count == MAX_VAL.
- err  out  1  one-cycle pulse on an illegal two-bit phase jump.

## Operation
- Synchronizer: two flops per channel. Debounce: the filtered {a,b} takes a new synchronized value only after DEB_CYCLES consecutive equal samples that differ from the current filtered value.
- Phase FSM states: INIT, S00, S10, S11, S01 (named by {a,b}).
  - Reset enters INIT. The first debounced sample after reset moves the FSM to the matching Sxx with no count and no err.
  - CW order: S00→S10→S11→S01→S00. Each CW transition adds +1 to the accumulator.
  - CCW order: the reverse. Each CCW transition adds −1 to the accumulator.
  - A diagonal jump (both bits change) moves to the new state, pulses err, and leaves the accumulator unchanged.
- Accumulator: signed, range −DETENT..+DETENT.
  - At +DETENT: pulse step_cw and reset the accumulator to 0.
  - At −DETENT: pulse step_ccw and reset the accumulator to 0.
  - A direction reversal mid-detent simply unwinds the accumulator.
- Counter, updated on a step pulse while enable=1:
  - CW: MAX_VAL→MIN_VAL if WRAP=1, otherwise hold at MAX_VAL; all other values count +1.
  - CCW: MIN_VAL→MAX_VAL if WRAP=1, otherwise hold at MIN_VAL; all other values count −1.
- clr: count←MIN_VAL and accumulator←0. clr has priority over a same-cycle step; the step pulse still fires but count shows MIN_VAL. clr does not change the FSM state.
- Reset values: count=MIN_VAL, step_cw=0, step_ccw=0, err=0, accumulator=0, filtered={0,0}, FSM=INIT. at_limit=1 out of reset, because count=MIN_VAL.

## Timing
- A pin change is captured by the sync flops. The filtered value updates DEB_CYCLES+2 clocks after the first sampling edge.
- Phase FSM, accumulator and step/err pulses are registered and assert 1 clock after the filtered value changes.
- count updates on the same clock edge that asserts the step pulse.
- Total latency: a stable pin change produces its step pulse DEB_CYCLES+3 clocks later.
- step_cw and step_ccw are never high together. Each pulse lasts exactly 1 cycle.
- At most one quarter-step is processed per filtered change.
- Reset asserted mid-detent discards the partial accumulator immediately (asynchronous clear).

## Structure
- Package enc_pkg:
  - quad_state_t enum (INIT, S00, S10, S11, S01).
  - Function giving the transition direction (+1, −1, 0, illegal) from a state pair.
- Sub-module enc_debounce: 2-bit synchronizer plus stability counter, parameter DEB_CYCLES; outputs filtered {a,b}.
- Top-level enc_count_ctrl contains the FSM, accumulator and counter.

## Test plan
All scenarios use WIDTH=8, MIN_VAL=0, MAX_VAL=9, DEB_CYCLES=4, DETENT=4, unless noted.
- Reset with pins {1,1}, hold 20 clocks → count=0, at_limit=1, no err, no steps.
- One full CW cycle 00→10→11→01→00, each level held 10 clocks → one step_cw exactly 7 clocks after the last edge; count=1.
- From count=9, one CW detent → count=0 (WRAP=1). Repeat with WRAP=0 → count stays 9 and step_cw still pulses.
- Two quarter-steps CW then two CCW → no step pulse; count unchanged. Follow with 4 CCW → step_ccw; count=9 (wrap from 0).
- Glitch on a shorter than 4 clocks → filtered value unchanged, no err. Jump 00→11 held 10 clocks → err pulses once, count unchanged.
- clr asserted in the same cycle as step_cw with count=5 → count=0 next cycle. enable=0 for 3 CW detents → three step_cw pulses, count unchanged.
